// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_ITERS = 32;
   // Working register is {R[32:0], Q[31:0]}.
   localparam int DIV_WR_W  = 2*DIV_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   typedef logic [5:0] div_cnt_t;

   // Magnitude of a signed operand, widened by one bit so |-2^31| fits.
   function automatic logic [DIV_WIDTH:0] div_abs(input logic [DIV_WIDTH-1:0] v);
      logic [DIV_WIDTH:0] ext;
      ext = {v[DIV_WIDTH-1], v};
      return v[DIV_WIDTH-1] ? -ext : ext;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on the {R,Q} working register.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module div_step
   import div_pkg::*;
(
   input  logic [DIV_WR_W-1:0] wr_in,
   input  logic [DIV_WIDTH:0]  divisor,
   output logic [DIV_WR_W-1:0] wr_out
);

   logic [DIV_WR_W-1:0] shifted;
   logic [DIV_WIDTH:0]  trial;

   // Shift in a zero, trial-subtract the divisor, keep the difference if it did not go negative.
   always_comb begin
      shifted = wr_in << 1;
      trial   = shifted[DIV_WR_W-1:DIV_WIDTH] - divisor;
      wr_out  = shifted;
      if (!trial[DIV_WIDTH]) begin
         wr_out[DIV_WR_W-1:DIV_WIDTH] = trial;
         wr_out[0]                    = 1'b1;
      end
   end

endmodule

// File: rtl/div_unit.sv
// Sequential 32-bit signed divider, one quotient bit per cycle, truncating toward zero.
// Latency: result pulse 34 cycles after the start edge, 1 cycle for a zero divisor.
// Backpressure: none; a new start in RUN/FIX aborts silently, a start in DONE or the pulse cycle is accepted.
module div_unit
   import div_pkg::*;
(
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 ctrl_div,
   input  logic [DIV_WIDTH-1:0] data_operandA,
   input  logic [DIV_WIDTH-1:0] data_operandB,
   output logic [DIV_WIDTH-1:0] data_result,
   output logic                 data_exception,
   output logic                 data_resultRDY,
   output logic                 busy
);

   div_state_t           state, state_nxt;
   logic [DIV_WR_W-1:0]  wr, wr_nxt;
   logic [DIV_WIDTH:0]   divisor;
   logic                 neg;
   div_cnt_t             cnt;
   logic [DIV_WIDTH-1:0] res_q;
   logic                 exc_q;

   logic                 b_zero;
   logic [DIV_WIDTH:0]   abs_a;
   logic [DIV_WIDTH:0]   abs_b;

   assign b_zero = (data_operandB == '0);
   assign abs_a  = div_abs(data_operandA);
   assign abs_b  = div_abs(data_operandB);

   div_step u_step (
      .wr_in   (wr),
      .divisor (divisor),
      .wr_out  (wr_nxt)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: a start wins in every state, otherwise walk RUN -> FIX -> DONE -> IDLE.
   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      if (ctrl_div) begin
         state_nxt = b_zero ? DONE : RUN;
      end else begin
         case (state)
            IDLE:    state_nxt = IDLE;
            RUN:     if (cnt == div_cnt_t'(DIV_ITERS-1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Datapath: operand capture on start, one iteration per RUN cycle, sign fix-up in FIX.
   always_ff @(posedge clk) begin
      if (clr) begin
         wr      <= '0;
         divisor <= '0;
         neg     <= 1'b0;
         cnt     <= '0;
         res_q   <= '0;
         exc_q   <= 1'b0;
      end else if (ctrl_div) begin
         if (b_zero) begin
            res_q <= '0;
            exc_q <= 1'b1;
         end else begin
            // abs_a <= 2^31, so its top bit is zero and lands harmlessly in R[0].
            wr      <= {{DIV_WIDTH{1'b0}}, abs_a};
            divisor <= abs_b;
            neg     <= data_operandA[DIV_WIDTH-1] ^ data_operandB[DIV_WIDTH-1];
            cnt     <= '0;
            exc_q   <= 1'b0;
         end
      end else begin
         case (state)
            RUN: begin
               wr  <= wr_nxt;
               cnt <= cnt + 6'd1;
            end
            FIX: res_q <= neg ? -wr[DIV_WIDTH-1:0] : wr[DIV_WIDTH-1:0];
            default: ;
         endcase
      end
   end

   // Outputs are published from DONE, so a start taken in DONE cannot disturb the pending pulse.
   always_ff @(posedge clk) begin
      if (clr) begin
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= (state == DONE);
         if (state == DONE) begin
            data_result    <= res_q;
            data_exception <= exc_q;
         end
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized operands against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_div_unit;

   logic        clk;
   logic        clr;
   logic        ctrl_div;
   logic [31:0] opA;
   logic [31:0] opB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int clr_edge = -1;
   bit armed = 0;

   typedef struct {
      int          start;
      int          due;
      logic [31:0] res;
      logic        exc;
   } op_t;
   op_t pend[$];

   div_unit dut (
      .clk            (clk),
      .clr            (clr),
      .ctrl_div       (ctrl_div),
      .data_operandA  (opA),
      .data_operandB  (opB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   // Reference: signed division truncating toward zero, zero divisor gives 0.
   function automatic logic [31:0] model_q(input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) return 32'd0;
      q = sa / sb;
      return q[31:0];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   // Compare process: every cycle, pulse/busy against the pending-operation list.
   always @(negedge clk) begin
      if (armed) begin
         logic        exp_rdy, exp_busy, ee;
         logic [31:0] er;
         exp_rdy = 1'b0; exp_busy = 1'b0; ee = 1'b0; er = '0;
         foreach (pend[i]) begin
            if (pend[i].due == cyc) begin
               exp_rdy = 1'b1; er = pend[i].res; ee = pend[i].exc;
            end
            if (cyc >= pend[i].start && cyc < pend[i].due) exp_busy = 1'b1;
         end
         chk("rdy",  32'(data_resultRDY), 32'(exp_rdy));
         chk("busy", 32'(busy),           32'(exp_busy));
         if (exp_rdy) begin
            chk("result",    data_result,         er);
            chk("exception", 32'(data_exception), 32'(ee));
         end
         if (cyc == clr_edge) begin
            chk("clr_result",    data_result,         32'd0);
            chk("clr_exception", 32'(data_exception), 32'd0);
         end
         for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i].due <= cyc) pend.delete(i);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic exc);
      int  e;
      op_t o;
      ctrl_div = 1'b1; opA = a; opB = b;
      e = cyc + 1;
      o.start = e;
      o.due   = (b == 32'd0) ? e + 1 : e + 34;
      o.res   = res;
      o.exc   = exc;
      pend.push_back(o);
      step();
      ctrl_div = 1'b0; opA = $urandom; opB = $urandom;
      // A newer start cancels any earlier operation that had not yet reached its pulse.
      for (int i = pend.size() - 1; i >= 0; i--)
         if (pend[i].start < e && pend[i].due > e) pend.delete(i);
   endtask

   task automatic start_model(input logic [31:0] a, input logic [31:0] b);
      start_op(a, b, model_q(a, b), b == 32'd0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (pend.size() != 0 && n < 200) begin
         step();
         n++;
      end
      if (pend.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL wait_idle timeout cyc=%0d pending=%0d", cyc, pend.size());
         pend.delete();
      end
   endtask

   task automatic do_clr();
      clr = 1'b1;
      clr_edge = cyc + 1;
      step();
      clr = 1'b0;
      pend.delete();
   endtask

   function automatic logic [31:0] rand_a();
      case ($urandom % 8)
         0:       return 32'h8000_0000;
         1:       return 32'd0;
         2:       return 32'h7FFF_FFFF;
         default: return $urandom >> $urandom_range(0, 31);
      endcase
   endfunction

   function automatic logic [31:0] rand_b();
      logic [31:0] m;
      case ($urandom % 10)
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'd1;
         3:       m = $urandom_range(1, 20);
         default: m = $urandom >> $urandom_range(0, 31);
      endcase
      return ($urandom % 2) ? -m : m;
   endfunction

   initial begin
      int d;
      clr = 1'b1; ctrl_div = 1'b0; opA = '0; opB = '0;
      step(); step();
      armed = 1;
      do_clr();
      repeat (2) step();

      // Pin the reference model to hand-computed values.
      chk("model 100/7",    model_q(32'd100, 32'd7),               32'd14);
      chk("model -100/7",   model_q(-32'sd100, 32'd7),             32'hFFFF_FFF2);
      chk("model min/-1",   model_q(32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
      chk("model 7/100",    model_q(32'd7, 32'd100),               32'd0);

      // Directed cases with literal expectations.
      start_op(32'd100, 32'd7, 32'd14, 1'b0);                      wait_idle();
      start_op(-32'sd100, 32'd7, 32'hFFFF_FFF2, 1'b0);             wait_idle();
      start_op(-32'sd100, -32'sd7, 32'd14, 1'b0);                  wait_idle();
      start_op(32'd5, 32'd0, 32'd0, 1'b1);                         wait_idle();
      start_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0); wait_idle();
      start_op(32'd7, 32'd100, 32'd0, 1'b0);                       wait_idle();

      // Abort: second start ten cycles after the first.
      start_op(32'd100, 32'd7, 32'd14, 1'b0);
      repeat (9) step();
      start_op(32'd9, 32'd3, 32'd3, 1'b0);
      wait_idle();

      // Reset in the middle of a run: outputs clear and no pulse follows.
      start_op(32'd100, 32'd7, 32'd14, 1'b0);
      repeat (19) step();
      do_clr();
      repeat (40) step();

      // Back-to-back: next start issued in the pulse cycle of the previous one.
      start_op(32'd20, 32'd3, 32'd6, 1'b0);
      d = pend[pend.size()-1].due;
      while (cyc < d) step();
      start_op(32'd50, 32'd5, 32'd10, 1'b0);
      wait_idle();

      // Randomized operands, with occasional aborts.
      for (int k = 0; k < 120; k++) begin
         if ($urandom % 6 == 0) begin
            start_model(rand_a(), rand_b());
            repeat ($urandom_range(0, 29)) step();
         end
         start_model(rand_a(), rand_b());
         wait_idle();
         repeat ($urandom_range(0, 3)) step();
      end

      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
